// File: rtl/noc_pkg.sv
// Shared NoC packet widths, field positions and slot state encoding for the
// request/response protocol.
package noc_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REQ_W  = 11;
  localparam int unsigned RESP_W = DATA_W + 9;

  localparam int unsigned REQ_VALID    = 0;
  localparam int unsigned REQ_TGT_LO   = 1;
  localparam int unsigned REQ_TGT_HI   = 2;
  localparam int unsigned REQ_SRC_LO   = 3;
  localparam int unsigned REQ_SRC_HI   = 4;
  localparam int unsigned REQ_REGID_LO = 5;
  localparam int unsigned REQ_REGID_HI = 10;

  localparam int unsigned RSP_VALID    = 0;
  localparam int unsigned RSP_DEST_LO  = 1;
  localparam int unsigned RSP_DEST_HI  = 2;
  localparam int unsigned RSP_REGID_LO = 3;
  localparam int unsigned RSP_REGID_HI = 8;
  localparam int unsigned RSP_DATA_LO  = 9;
  localparam int unsigned RSP_DATA_HI  = RESP_W - 1;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } slot_state_e;

  function automatic logic [REQ_W-1:0] build_req(input logic [5:0] reg_id,
                                                 input logic [1:0] src,
                                                 input logic [1:0] tgt);
    logic [REQ_W-1:0] pkt;
    pkt = '0;
    pkt[REQ_REGID_HI:REQ_REGID_LO] = reg_id;
    pkt[REQ_SRC_HI:REQ_SRC_LO]     = src;
    pkt[REQ_TGT_HI:REQ_TGT_LO]     = tgt;
    pkt[REQ_VALID]                 = 1'b1;
    return pkt;
  endfunction

endpackage

// File: rtl/requester_if.sv
// Command, NoC and result signals of the requester grouped into one bundle.
interface requester_if;
  import noc_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [5:0]        cmd_reg_id;
  logic [1:0]        cmd_target;
  logic              full;
  logic              almost_full;
  logic [REQ_W-1:0]  dataOut;
  logic              write;
  logic [RESP_W-1:0] dataIn;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [5:0]        rsp_reg_id;
  logic              rsp_error;

  modport master (
    input  cmd_valid, cmd_reg_id, cmd_target, full, almost_full, dataIn,
    output cmd_ready, dataOut, write, rsp_valid, rsp_data, rsp_reg_id, rsp_error
  );

  modport slave (
    output cmd_valid, cmd_reg_id, cmd_target, full, almost_full, dataIn,
    input  cmd_ready, dataOut, write, rsp_valid, rsp_data, rsp_reg_id, rsp_error
  );

endinterface

// File: rtl/req_slot.sv
// One outstanding-request slot: FREE/SEND/WAIT state, response timer and
// retry count.
module req_slot
  import noc_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alloc,
  input  logic [5:0] alloc_reg_id,
  input  logic [1:0] alloc_target,
  input  logic       send_grant,
  input  logic       rsp_hit,
  input  logic       err_grant,
  input  logic [5:0] cmd_reg_id,
  input  logic [5:0] rsp_reg_id,
  output logic       is_free,
  output logic       want_send,
  output logic       match,
  output logic       dup,
  output logic       timeout_err,
  output logic [5:0] reg_id,
  output logic [1:0] target
);

  localparam logic [7:0] TIMEOUT_T = 8'(TIMEOUT);
  localparam logic [1:0] RETRY_T   = 2'(MAX_RETRY);

  slot_state_e state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [1:0]  retry_q, retry_d;
  logic [5:0]  reg_id_q, reg_id_d;
  logic [1:0]  target_q, target_d;
  logic        at_limit;

  assign at_limit = (timer_q == TIMEOUT_T);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FREE;
      timer_q  <= '0;
      retry_q  <= '0;
      reg_id_q <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      retry_q  <= retry_d;
      reg_id_q <= reg_id_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    retry_d  = retry_q;
    reg_id_d = reg_id_q;
    target_d = target_q;
    unique case (state_q)
      FREE: begin
        if (alloc) begin
          state_d  = SEND;
          timer_d  = '0;
          retry_d  = '0;
          reg_id_d = alloc_reg_id;
          target_d = alloc_target;
        end
      end
      SEND: begin
        if (rsp_hit) begin
          state_d = FREE;
        end else if (send_grant) begin
          state_d = WAIT;
          timer_d = '0;
        end
      end
      WAIT: begin
        // An exhausted slot parks at the limit until its error is granted.
        if (rsp_hit) begin
          state_d = FREE;
        end else if (at_limit) begin
          if (retry_q < RETRY_T) begin
            state_d = SEND;
            retry_d = retry_q + 2'd1;
          end else if (err_grant) begin
            state_d = FREE;
          end
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = FREE;
    endcase
  end

  assign is_free     = (state_q == FREE);
  assign want_send   = (state_q == SEND);
  assign match       = !is_free && (reg_id_q == rsp_reg_id);
  assign dup         = !is_free && (reg_id_q == cmd_reg_id);
  assign timeout_err = (state_q == WAIT) && at_limit && (retry_q >= RETRY_T);
  assign reg_id      = reg_id_q;
  assign target      = target_q;

endmodule

// File: rtl/requester.sv
// NoC initiator: allocates request slots, serialises request packets and
// reports matched responses or timeout errors upstream.
module requester
  import noc_pkg::*;
#(
  parameter int unsigned MAX_OUT   = 4,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   id,
  requester_if.master  bus,
  output logic [2:0]   outstanding,
  output logic [7:0]   stray_cnt
);

  localparam int unsigned IDX_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [MAX_OUT-1:0] is_free, want_send, match, dup, timeout_err;
  logic [MAX_OUT-1:0] alloc_vec, send_vec, err_vec, hit_vec;
  logic [5:0]         slot_reg_id [MAX_OUT];
  logic [1:0]         slot_target [MAX_OUT];

  logic               rsp_accept, any_hit, blocked, cmd_accept;
  logic               alloc_found, send_found, err_found;
  logic [IDX_W-1:0]   send_idx, err_idx;
  logic [5:0]         rsp_reg;
  logic [2:0]         busy_cnt;

  logic               write_q;
  logic [REQ_W-1:0]   data_out_q;
  logic               rsp_valid_q, rsp_error_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic [5:0]         rsp_reg_id_q;
  logic [7:0]         stray_q;

  assign rsp_reg    = bus.dataIn[RSP_REGID_HI:RSP_REGID_LO];
  assign rsp_accept = bus.dataIn[RSP_VALID] && (bus.dataIn[RSP_DEST_HI:RSP_DEST_LO] == id);
  assign hit_vec    = match & {MAX_OUT{rsp_accept}};
  assign any_hit    = |hit_vec;
  assign blocked    = (write_q & bus.almost_full) | (~write_q & bus.full);

  assign bus.cmd_ready = (|is_free) && !(|dup);
  assign cmd_accept    = bus.cmd_valid && bus.cmd_ready;

  for (genvar g = 0; g < MAX_OUT; g++) begin : g_slot
    req_slot #(
      .TIMEOUT   (TIMEOUT),
      .MAX_RETRY (MAX_RETRY)
    ) u_slot (
      .clk          (clk),
      .reset        (reset),
      .alloc        (alloc_vec[g]),
      .alloc_reg_id (bus.cmd_reg_id),
      .alloc_target (bus.cmd_target),
      .send_grant   (send_vec[g]),
      .rsp_hit      (hit_vec[g]),
      .err_grant    (err_vec[g]),
      .cmd_reg_id   (bus.cmd_reg_id),
      .rsp_reg_id   (rsp_reg),
      .is_free      (is_free[g]),
      .want_send    (want_send[g]),
      .match        (match[g]),
      .dup          (dup[g]),
      .timeout_err  (timeout_err[g]),
      .reg_id       (slot_reg_id[g]),
      .target       (slot_target[g])
    );
  end

  // Lowest-index priority for allocation, sending and error reporting. A slot
  // being completed by a response this cycle is not a send candidate.
  always_comb begin
    alloc_vec   = '0;
    send_vec    = '0;
    err_vec     = '0;
    alloc_found = 1'b0;
    send_found  = 1'b0;
    err_found   = 1'b0;
    send_idx    = '0;
    err_idx     = '0;
    for (int unsigned i = 0; i < MAX_OUT; i++) begin
      if (!alloc_found && is_free[i]) begin
        alloc_found  = 1'b1;
        alloc_vec[i] = cmd_accept;
      end
      if (!send_found && want_send[i] && !hit_vec[i]) begin
        send_found  = 1'b1;
        send_idx    = IDX_W'(i);
        send_vec[i] = !blocked;
      end
      if (!err_found && timeout_err[i]) begin
        err_found  = 1'b1;
        err_idx    = IDX_W'(i);
        err_vec[i] = !any_hit;
      end
    end
  end

  always_comb begin
    busy_cnt = '0;
    for (int unsigned i = 0; i < MAX_OUT; i++) begin
      if (!is_free[i]) busy_cnt = busy_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_q      <= 1'b0;
      data_out_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_reg_id_q <= '0;
      rsp_error_q  <= 1'b0;
      stray_q      <= '0;
    end else begin
      write_q <= send_found && !blocked;
      if (send_found && !blocked) begin
        data_out_q <= build_req(slot_reg_id[send_idx], id, slot_target[send_idx]);
      end
      rsp_valid_q <= any_hit || err_found;
      if (any_hit) begin
        rsp_data_q   <= bus.dataIn[RSP_DATA_HI:RSP_DATA_LO];
        rsp_reg_id_q <= rsp_reg;
        rsp_error_q  <= 1'b0;
      end else if (err_found) begin
        rsp_data_q   <= '0;
        rsp_reg_id_q <= slot_reg_id[err_idx];
        rsp_error_q  <= 1'b1;
      end
      if (rsp_accept && !any_hit && (stray_q != 8'hFF)) begin
        stray_q <= stray_q + 8'd1;
      end
    end
  end

  assign bus.write      = write_q;
  assign bus.dataOut    = data_out_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_reg_id = rsp_reg_id_q;
  assign bus.rsp_error  = rsp_error_q;
  assign outstanding    = busy_cnt;
  assign stray_cnt      = stray_q;

endmodule

// File: tb/tb_requester.sv
// Self-checking bench for requester: timestamp-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_requester;
  import noc_pkg::*;

  localparam int MAX_OUT   = 4;
  localparam int TIMEOUT   = 255;
  localparam int MAX_RETRY = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] id;
  logic [2:0] outstanding;
  logic [7:0] stray_cnt;

  requester_if bus();

  requester #(
    .MAX_OUT   (MAX_OUT),
    .TIMEOUT   (TIMEOUT),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id          (id),
    .bus         (bus),
    .outstanding (outstanding),
    .stray_cnt   (stray_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding requests kept per slot with the edge index of
  // their last transmission; deadlines are computed from timestamps.
  bit         m_used    [MAX_OUT];
  bit         m_pending [MAX_OUT];
  logic [5:0] m_reg     [MAX_OUT];
  logic [1:0] m_tgt     [MAX_OUT];
  int         m_sends   [MAX_OUT];
  int         m_tsent   [MAX_OUT];
  int         now = 0;

  logic        exp_write = 1'b0;
  logic [10:0] exp_dout  = '0;
  logic        exp_rv    = 1'b0;
  logic [15:0] exp_rd    = '0;
  logic [5:0]  exp_rreg  = '0;
  logic        exp_rerr  = 1'b0;
  int          exp_stray = 0;

  function automatic bit m_ready(input logic [5:0] r);
    bit any_free = 1'b0;
    bit dupl     = 1'b0;
    for (int i = 0; i < MAX_OUT; i++) begin
      if (!m_used[i]) any_free = 1'b1;
      else if (m_reg[i] == r) dupl = 1'b1;
    end
    return any_free && !dupl;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < MAX_OUT; i++) if (m_used[i]) c++;
    return c;
  endfunction

  always @(posedge clk) begin : model
    int hit, snd, err, alc;
    bit acc, blk, rdy;
    now++;
    if (reset) begin
      for (int i = 0; i < MAX_OUT; i++) begin
        m_used[i] = 1'b0; m_pending[i] = 1'b0; m_reg[i] = '0; m_tgt[i] = '0;
        m_sends[i] = 0; m_tsent[i] = 0;
      end
      exp_write = 1'b0; exp_dout = '0; exp_rv = 1'b0; exp_rd = '0;
      exp_rreg = '0; exp_rerr = 1'b0; exp_stray = 0;
    end else begin
      acc = bus.dataIn[0] && (bus.dataIn[2:1] == id);
      hit = -1;
      if (acc) for (int i = 0; i < MAX_OUT; i++)
        if (m_used[i] && m_reg[i] == bus.dataIn[8:3]) hit = i;
      rdy = m_ready(bus.cmd_reg_id);
      blk = exp_write ? bus.almost_full : bus.full;
      snd = -1;
      for (int i = MAX_OUT - 1; i >= 0; i--)
        if (m_used[i] && m_pending[i] && i != hit) snd = i;
      err = -1;
      if (hit < 0) for (int i = MAX_OUT - 1; i >= 0; i--)
        if (m_used[i] && !m_pending[i] && (now - m_tsent[i] > TIMEOUT) && m_sends[i] > MAX_RETRY)
          err = i;
      alc = -1;
      if (bus.cmd_valid && rdy) for (int i = MAX_OUT - 1; i >= 0; i--)
        if (!m_used[i]) alc = i;

      exp_rv = (hit >= 0) || (err >= 0);
      if (hit >= 0) begin
        exp_rd = bus.dataIn[24:9]; exp_rreg = bus.dataIn[8:3]; exp_rerr = 1'b0;
      end else if (err >= 0) begin
        exp_rd = '0; exp_rreg = m_reg[err]; exp_rerr = 1'b1;
      end
      if (acc && hit < 0 && exp_stray < 255) exp_stray++;
      exp_write = 1'b0;
      if (!blk && snd >= 0) begin
        exp_write = 1'b1;
        exp_dout  = {m_reg[snd], id, m_tgt[snd], 1'b1};
      end

      for (int i = 0; i < MAX_OUT; i++)
        if (m_used[i] && !m_pending[i] && i != hit && (now - m_tsent[i] == TIMEOUT + 1)
            && m_sends[i] <= MAX_RETRY)
          m_pending[i] = 1'b1;
      if (hit >= 0) m_used[hit] = 1'b0;
      if (err >= 0) m_used[err] = 1'b0;
      if (!blk && snd >= 0) begin
        m_pending[snd] = 1'b0; m_tsent[snd] = now; m_sends[snd]++;
      end
      if (alc >= 0) begin
        m_used[alc] = 1'b1; m_pending[alc] = 1'b1; m_reg[alc] = bus.cmd_reg_id;
        m_tgt[alc] = bus.cmd_target; m_sends[alc] = 0; m_tsent[alc] = now;
      end
    end
  end

  always @(negedge clk) begin : compare
    if (cmp_en) begin
      check("write", bus.write, exp_write);
      check("dataOut", bus.dataOut, exp_dout);
      check("rsp_valid", bus.rsp_valid, exp_rv);
      if (exp_rv) begin
        check("rsp_data", bus.rsp_data, exp_rd);
        check("rsp_reg_id", bus.rsp_reg_id, exp_rreg);
        check("rsp_error", bus.rsp_error, exp_rerr);
      end
      check("outstanding", outstanding, m_count());
      check("stray_cnt", stray_cnt, exp_stray);
      check("cmd_ready", bus.cmd_ready, m_ready(bus.cmd_reg_id));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int writes, n;
    reset = 1'b1; id = 2'd1;
    bus.cmd_valid = 1'b0; bus.cmd_reg_id = '0; bus.cmd_target = '0;
    bus.full = 1'b0; bus.almost_full = 1'b0; bus.dataIn = '0;
    repeat (3) tick();
    cmp_en = 1'b1;
    check("reset_write", bus.write, 0);
    check("reset_dataOut", bus.dataOut, 0);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_rsp_data", bus.rsp_data, 0);
    check("reset_rsp_reg_id", bus.rsp_reg_id, 0);
    check("reset_rsp_error", bus.rsp_error, 0);
    check("reset_stray", stray_cnt, 0);
    check("reset_outstanding", outstanding, 0);
    reset = 1'b0;
    tick();

    // Single read, matched response
    bus.cmd_valid = 1'b1; bus.cmd_reg_id = 6'd5; bus.cmd_target = 2'd2;
    #1 check("t1_ready", bus.cmd_ready, 1);
    tick(); bus.cmd_valid = 1'b0;
    check("t1_no_write_yet", bus.write, 0);
    check("t1_outstanding", outstanding, 1);
    tick();
    check("t1_write", bus.write, 1);
    check("t1_dataOut", bus.dataOut, 11'b000101_01_10_1);
    bus.dataIn = {16'hBEEF, 6'd5, 2'd1, 1'b1};
    tick(); bus.dataIn = '0;
    check("t1_rsp_valid", bus.rsp_valid, 1);
    check("t1_rsp_data", bus.rsp_data, 16'hBEEF);
    check("t1_rsp_reg_id", bus.rsp_reg_id, 5);
    check("t1_rsp_error", bus.rsp_error, 0);
    check("t1_outstanding0", outstanding, 0);
    tick();
    check("t1_pulse_end", bus.rsp_valid, 0);

    // Back-pressure: full, then almost_full while writing
    bus.full = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_reg_id = 6'd7; bus.cmd_target = 2'd0;
    tick(); bus.cmd_reg_id = 6'd8; bus.cmd_target = 2'd3;
    tick(); bus.cmd_valid = 1'b0;
    repeat (3) begin tick(); check("t2_full_hold", bus.write, 0); end
    check("t2_outstanding", outstanding, 2);
    bus.full = 1'b0; bus.almost_full = 1'b1;
    tick();
    check("t2_write_after_full", bus.write, 1);
    check("t2_dataOut7", bus.dataOut, 11'b000111_01_00_1);
    tick();
    check("t2_almost_full_block", bus.write, 0);
    bus.almost_full = 1'b0;
    tick();
    check("t2_write8", bus.write, 1);
    check("t2_dataOut8", bus.dataOut, 11'b001000_01_11_1);
    bus.dataIn = {16'h0007, 6'd7, 2'd1, 1'b1}; tick();
    check("t2_rsp7", bus.rsp_reg_id, 7);
    bus.dataIn = {16'h0008, 6'd8, 2'd1, 1'b1}; tick();
    check("t2_rsp8_data", bus.rsp_data, 16'h0008);
    bus.dataIn = '0; tick();

    // Fill all slots, refuse 5th and duplicate
    bus.full = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_target = 2'd3;
    for (int i = 0; i < 4; i++) begin bus.cmd_reg_id = 6'(10 + i); tick(); end
    bus.cmd_reg_id = 6'd20;
    #1 check("t3_full_ready", bus.cmd_ready, 0);
    check("t3_outstanding4", outstanding, 4);
    tick(); bus.cmd_valid = 1'b0;
    check("t3_refused", outstanding, 4);
    bus.dataIn = {16'hAAAA, 6'd10, 2'd1, 1'b1}; tick(); bus.dataIn = '0;
    check("t3_late_send_match", bus.rsp_reg_id, 10);
    check("t3_outstanding3", outstanding, 3);
    bus.cmd_reg_id = 6'd11;
    #1 check("t3_dup_refused", bus.cmd_ready, 0);
    bus.cmd_reg_id = 6'd20;
    #1 check("t3_new_ok", bus.cmd_ready, 1);
    for (int i = 1; i < 4; i++) begin
      bus.dataIn = {16'(i), 6'(10 + i), 2'd1, 1'b1}; tick();
      check("t3_drain", bus.rsp_reg_id, 10 + i);
    end
    bus.dataIn = '0; bus.full = 1'b0; tick();
    check("t3_empty", outstanding, 0);

    // Timeout with retries
    bus.cmd_valid = 1'b1; bus.cmd_reg_id = 6'd33; bus.cmd_target = 2'd1;
    tick(); bus.cmd_valid = 1'b0;
    writes = 0; n = 0;
    while (!bus.rsp_valid && n < 2000) begin
      if (bus.write) writes++;
      tick(); n++;
    end
    check("t4_latency", n, 771);
    check("t4_writes", writes, 3);
    check("t4_rsp_error", bus.rsp_error, 1);
    check("t4_rsp_data", bus.rsp_data, 0);
    check("t4_rsp_reg_id", bus.rsp_reg_id, 33);
    tick();
    check("t4_freed", outstanding, 0);

    // Foreign destination and stray response
    bus.dataIn = {16'h1234, 6'd5, 2'd2, 1'b1}; tick(); bus.dataIn = '0;
    check("t5_foreign_rv", bus.rsp_valid, 0);
    check("t5_foreign_stray", stray_cnt, 0);
    bus.dataIn = {16'h1234, 6'd9, 2'd1, 1'b1}; tick(); bus.dataIn = '0;
    check("t5_stray_rv", bus.rsp_valid, 0);
    check("t5_stray", stray_cnt, 1);

    // Reset mid-operation, late response becomes stray, saturation
    bus.full = 1'b1; bus.cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin bus.cmd_reg_id = 6'(40 + i); tick(); end
    bus.cmd_valid = 1'b0;
    check("t6_outstanding3", outstanding, 3);
    reset = 1'b1; tick(); reset = 1'b0;
    check("t6_reset_outstanding", outstanding, 0);
    check("t6_reset_write", bus.write, 0);
    bus.dataIn = {16'h4040, 6'd40, 2'd1, 1'b1}; tick();
    check("t6_late_stray", stray_cnt, 1);
    check("t6_late_rv", bus.rsp_valid, 0);
    repeat (300) tick();
    check("t6_stray_sat", stray_cnt, 255);
    bus.dataIn = '0; bus.full = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
